// File: rtl/osiris_uart_pkg.sv
// rtl/osiris_uart_pkg.sv - shared UART host constants, FSM state type and bit-timing helper
package osiris_uart_pkg;

  localparam logic [7:0] CMD_READ_DEF  = 8'h01;
  localparam logic [7:0] CMD_WRITE_DEF = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_ADDR,
    SEND_DATA,
    RECV_DATA,
    RESP
  } host_state_e;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_phy_8n1.sv
// rtl/uart_phy_8n1.sv - 8N1 byte transmitter, mid-bit byte receiver and RX synchronizer
module uart_phy_8n1 #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_uart_tx,
  input  logic       i_uart_rx,
  input  logic       i_rx_en,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_rx_frame_err,
  output logic       o_rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_tx;
  logic          r_tx_active;
  logic [3:0]    r_tx_bit;
  logic [CW-1:0] r_tx_clk;
  logic [7:0]    r_tx_data;

  logic          r_sync1, r_sync2;
  logic          r_armed;
  logic          r_rx_busy;
  logic          r_rx_valid;
  logic          r_rx_err;
  logic [3:0]    r_rx_bit;
  logic [CW-1:0] r_rx_clk;
  logic [7:0]    r_rx_data;

  assign o_uart_tx      = r_tx;
  assign o_tx_busy      = r_tx_active;
  assign o_tx_done      = r_tx_active && (r_tx_clk == LAST) && (r_tx_bit == 4'd9);
  assign o_rx_byte      = r_rx_data;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_frame_err = r_rx_err;
  assign o_rx_busy      = r_rx_busy;

  // A start request during the final stop-bit cycle reloads directly, so bytes run gap-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_bit    <= 4'd0;
      r_tx_clk    <= '0;
      r_tx_data   <= 8'h00;
    end else if (i_tx_start && (!r_tx_active || o_tx_done)) begin
      r_tx        <= 1'b0;
      r_tx_active <= 1'b1;
      r_tx_bit    <= 4'd0;
      r_tx_clk    <= '0;
      r_tx_data   <= i_tx_byte;
    end else if (r_tx_active) begin
      if (r_tx_clk != LAST) begin
        r_tx_clk <= r_tx_clk + 1'b1;
      end else begin
        r_tx_clk <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_active <= 1'b0;
          r_tx        <= 1'b1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
          r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_data[r_tx_bit[2:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Disabled receiver forgets everything; it must see idle-high again before hunting a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b0;
      r_rx_busy  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_bit   <= 4'd0;
      r_rx_clk   <= '0;
      r_rx_data  <= 8'h00;
    end else if (!i_rx_en) begin
      r_armed    <= 1'b0;
      r_rx_busy  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (!r_armed) begin
        r_armed <= r_sync2;
      end else if (!r_rx_busy) begin
        if (!r_sync2) begin
          r_rx_busy <= 1'b1;
          r_rx_bit  <= 4'd0;
          r_rx_clk  <= HALF;
        end
      end else if (r_rx_clk != '0) begin
        r_rx_clk <= r_rx_clk - 1'b1;
      end else begin
        r_rx_clk <= LAST;
        if (r_rx_bit == 4'd0) begin
          if (r_sync2) r_rx_busy <= 1'b0;
          else         r_rx_bit  <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy  <= 1'b0;
          r_rx_valid <= 1'b1;
          r_rx_err   <= !r_sync2;
        end else begin
          r_rx_data <= {r_sync2, r_rx_data[7:1]};
          r_rx_bit  <= r_rx_bit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - request-driven UART host that frames single-word reads/writes for the bridge
module uart_wb_host
  import osiris_uart_pkg::*;
#(
  parameter int          DATA_WIDTH        = 32,
  parameter int          ADDR_WIDTH        = 32,
  parameter int          BAUD_RATE         = 9600,
  parameter int          CLOCK_FREQ        = 50000000,
  parameter logic [7:0]  CMD_READ          = CMD_READ_DEF,
  parameter logic [7:0]  CMD_WRITE         = CMD_WRITE_DEF,
  parameter int          RESP_TIMEOUT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_uart_tx,
  input  logic                  i_uart_rx,
  output logic                  o_start_rx
);
  localparam int CPB       = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int TO_CYCLES = RESP_TIMEOUT_BITS * CPB;
  localparam int TOW       = $clog2(TO_CYCLES);
  localparam int FW        = 8 + ADDR_WIDTH + DATA_WIDTH;

  host_state_e           r_state, w_next;
  logic [FW-1:0]         r_frame;
  logic [3:0]            r_left;
  logic                  r_we;
  logic [1:0]            r_cnt;
  logic [TOW-1:0]        r_to;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_accept, w_sending, w_tx_start, w_tx_busy, w_tx_done;
  logic                  w_rx_en, w_rx_valid, w_rx_err, w_rx_busy, w_timeout;
  logic [7:0]            w_rx_byte;
  logic                  w_fin_err;
  logic [DATA_WIDTH-1:0] w_fin_data;

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_sending   = (r_state == SEND_CMD) || (r_state == SEND_ADDR) || (r_state == SEND_DATA);
  assign o_start_rx  = w_sending;
  assign w_rx_en     = (r_state == RECV_DATA);
  assign w_timeout   = (r_to == TOW'(TO_CYCLES - 1));
  // r_frame always presents the next byte to launch in its top 8 bits.
  assign w_tx_start  = w_sending && (r_left != 4'd0) && (!w_tx_busy || w_tx_done);

  uart_phy_8n1 #(
    .CLKS_PER_BIT(CPB)
  ) u_phy (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tx_start    (w_tx_start),
    .i_tx_byte     (r_frame[FW-1 -: 8]),
    .o_tx_busy     (w_tx_busy),
    .o_tx_done     (w_tx_done),
    .o_uart_tx     (o_uart_tx),
    .i_uart_rx     (i_uart_rx),
    .i_rx_en       (w_rx_en),
    .o_rx_byte     (w_rx_byte),
    .o_rx_valid    (w_rx_valid),
    .o_rx_frame_err(w_rx_err),
    .o_rx_busy     (w_rx_busy)
  );

  always_comb begin
    w_next     = r_state;
    w_fin_err  = 1'b0;
    w_fin_data = '0;
    case (r_state)
      IDLE:      if (w_accept) w_next = SEND_CMD;
      SEND_CMD:  if (w_tx_done) w_next = SEND_ADDR;
      SEND_ADDR: if (w_tx_done && r_cnt == 2'd3) w_next = r_we ? SEND_DATA : RECV_DATA;
      SEND_DATA: if (w_tx_done && r_cnt == 2'd3) w_next = RESP;
      RECV_DATA: begin
        if (w_rx_valid) begin
          if (w_rx_err) begin
            w_next    = RESP;
            w_fin_err = 1'b1;
          end else if (r_cnt == 2'd3) begin
            w_next     = RESP;
            w_fin_data = {r_acc[DATA_WIDTH-9:0], w_rx_byte};
          end
        end else if (w_timeout) begin
          w_next    = RESP;
          w_fin_err = 1'b1;
        end
      end
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_left      <= 4'd0;
      r_we        <= 1'b0;
      r_cnt       <= 2'd0;
      r_to        <= '0;
      r_acc       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_frame <= {(i_req_we ? CMD_WRITE : CMD_READ), i_req_addr, i_req_wdata};
        r_left  <= i_req_we ? 4'(1 + ADDR_WIDTH / 8 + DATA_WIDTH / 8) : 4'(1 + ADDR_WIDTH / 8);
        r_we    <= i_req_we;
      end else if (w_tx_start) begin
        r_frame <= r_frame << 8;
        r_left  <= r_left - 4'd1;
      end

      if (w_next != r_state)
        r_cnt <= 2'd0;
      else if ((w_sending && w_tx_done) || (w_rx_en && w_rx_valid))
        r_cnt <= r_cnt + 2'd1;

      if (w_accept)
        r_acc <= '0;
      else if (w_rx_en && w_rx_valid)
        r_acc <= {r_acc[DATA_WIDTH-9:0], w_rx_byte};

      // Timeout window restarts after each byte and pauses while a byte is being received.
      if (!w_rx_en || w_rx_valid)
        r_to <= '0;
      else if (!w_rx_busy && !w_timeout)
        r_to <= r_to + 1'b1;

      if (r_state != RESP && w_next == RESP) begin
        r_rsp_rdata <= w_fin_data;
        r_rsp_err   <= w_fin_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// tb/tb_uart_wb_host.sv - randomized self-checking bench for uart_wb_host with serial BFM and frame model
module tb_uart_wb_host;
  localparam int CPB     = 8;
  localparam int TO_BITS = 4;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_we, i_uart_rx;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_uart_tx, o_start_rx;
  logic [31:0] o_rsp_rdata;

  int          checks = 0, passes = 0, cyc = 0, acc_cyc = 0, bad_ready = 0;
  bit          pending = 0;
  logic [7:0]  tx_q[$];
  rsp_t        rsp_q[$];

  always #5 clk = ~clk;

  uart_wb_host #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BAUD_RATE(1), .CLOCK_FREQ(8),
    .CMD_READ(8'h01), .CMD_WRITE(8'hAA), .RESP_TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_uart_tx(o_uart_tx), .i_uart_rx(i_uart_rx), .o_start_rx(o_start_rx)
  );

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) pending = 0;
    else if (i_req_valid && o_req_ready) begin
      acc_cyc = cyc;
      pending = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && o_rsp_valid) begin
      rsp_q.push_back('{cyc, o_rsp_rdata, o_rsp_err});
      pending = 0;
    end else if (rst_n && pending && o_req_ready) begin
      bad_ready++;
    end
  end

  // Serial decoder for the host TX line: samples each bit at its middle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge o_uart_tx);
      #(CPB * 5 + 2);
      if (o_uart_tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        #(CPB * 10);
        b[i] = o_uart_tx;
      end
      #(CPB * 10);
      tx_q.push_back((o_uart_tx === 1'b1) ? b : 8'hxx);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic hold_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_uart_rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      hold_bit();
    end
    i_uart_rx = stop;
    hold_bit();
    i_uart_rx = 1'b1;
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, output bit ok);
    @(negedge clk);
    i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (o_req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_q.size() != 0) begin
        got = 1;
        break;
      end
    end
  endtask

  // mode: 0 = bridge replies with rword, 1 = no reply; bad_idx >= 0 sends that reply byte with stop=0
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int mode, input logic [31:0] rword, input int bad_idx, input string tag);
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    bit          ok, got, timed;
    rsp_t        r;
    tx_q.delete();
    rsp_q.delete();
    bad_ready = 0;
    exp_tx.push_back(we ? 8'hAA : 8'h01);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(8'((addr >> (8 * i)) & 32'hFF));
    if (we) for (int i = 3; i >= 0; i--) exp_tx.push_back(8'((wdata >> (8 * i)) & 32'hFF));
    exp_lat = 1 + exp_tx.size() * 10 * CPB;
    timed   = we || (mode == 1);
    if (we) begin
      exp_rd = 32'h0; exp_err = 1'b0;
    end else if (mode == 1) begin
      exp_rd = 32'h0; exp_err = 1'b1; exp_lat += TO_BITS * CPB;
    end else if (bad_idx >= 0) begin
      exp_rd = 32'h0; exp_err = 1'b1;
    end else begin
      exp_rd = rword; exp_err = 1'b0;
    end

    issue(we, addr, wdata, ok);
    chk({tag, "_accept"}, ok, 1'b1);
    if (!we && mode == 0) begin
      for (int i = 0; i < 1000 && o_start_rx; i++) @(negedge clk);
      chk({tag, "_start_rx_drop"}, o_start_rx, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        send_byte(8'((rword >> (8 * (3 - i))) & 32'hFF), (i == bad_idx) ? 1'b0 : 1'b1);
        if (i == bad_idx) break;
      end
    end
    wait_rsp(3000, got);
    chk({tag, "_rsp_seen"}, got, 1'b1);
    if (got) begin
      r = rsp_q.pop_front();
      chk({tag, "_err"}, r.err, exp_err);
      chk({tag, "_rdata"}, r.rdata, exp_rd);
      if (timed) chk({tag, "_latency"}, r.cyc - acc_cyc, exp_lat);
      @(negedge clk);
      chk({tag, "_ready_after"}, o_req_ready, 1'b1);
      repeat (3) @(negedge clk);
      chk({tag, "_rdata_hold"}, o_rsp_rdata, exp_rd);
    end
    chk({tag, "_tx_len"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      chk($sformatf("%s_tx_byte%0d", tag, i), tx_q[i], exp_tx[i]);
    chk({tag, "_ready_low"}, bad_ready, 0);
  endtask

  initial begin
    bit ok;
    bit we;
    rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_addr = 32'h0; i_req_wdata = 32'h0; i_uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", o_uart_tx, 1'b1);
    chk("rst_ready", o_req_ready, 1'b1);
    chk("rst_start_rx", o_start_rx, 1'b0);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    chk("rst_err", o_rsp_err, 1'b0);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, -1, "wr_basic");
    do_txn(1'b0, 32'h0000_0004, 32'h0, 0, 32'h1234_5678, -1, "rd_basic");
    do_txn(1'b0, 32'h0000_0008, 32'h0, 1, 32'h0, -1, "rd_timeout");
    do_txn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 0, 32'h0, -1, "wr_after_to");
    do_txn(1'b0, 32'h0000_000C, 32'h0, 0, 32'hA1B2_C3D4, 2, "rd_frame_err");
    do_txn(1'b0, 32'h0000_000C, 32'h0, 0, 32'hCAFE_0001, -1, "rd_after_fe");

    // Abort a write partway through the third address byte.
    tx_q.delete();
    rsp_q.delete();
    issue(1'b1, 32'h1122_3344, 32'h5566_7788, ok);
    chk("midrst_accept", ok, 1'b1);
    repeat (3 * 10 * CPB + 20) @(posedge clk);
    #3;
    chk("midrst_start_rx_before", o_start_rx, 1'b1);
    chk("midrst_bytes_before", tx_q.size(), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", o_uart_tx, 1'b1);
    chk("midrst_ready", o_req_ready, 1'b1);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    chk("midrst_no_rsp", rsp_q.size(), 0);
    chk("midrst_tx_idle", o_uart_tx, 1'b1);

    do_txn(1'b1, 32'h0000_0040, 32'h8765_4321, 0, 32'h0, -1, "wr_post_rst");
    do_txn(1'b0, 32'h0000_0044, 32'h0, 0, 32'h0F1E_2D3C, -1, "rd_post_rst");
    do_txn(1'b1, 32'h0000_0000, 32'h0000_0000, 0, 32'h0, -1, "wr_zero");
    do_txn(1'b0, 32'h0000_0000, 32'h0, 0, 32'h0000_0000, -1, "rd_zero");

    // Line activity outside the receive window must not leak into later reads.
    fork
      do_txn(1'b1, 32'h0000_0050, 32'h1357_9BDF, 0, 32'h0, -1, "wr_noise");
      begin
        repeat (200) @(posedge clk);
        #1;
        send_byte(8'h00, 1'b1);
      end
    join
    send_byte(8'hF0, 1'b1);
    repeat (5) @(posedge clk);
    do_txn(1'b0, 32'h0000_0054, 32'h0, 0, 32'h2468_ACE0, -1, "rd_after_noise");

    for (int n = 0; n < 6; n++) begin
      we = 1'($urandom_range(0, 1));
      do_txn(we, $urandom, $urandom, 0, $urandom, -1, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_wb_host.md
Name: uart_wb_host

Overview:
- Host-side counterpart of uart_wbs_bridge.
- Accepts single-word read/write requests over a valid/ready interface and serializes them as the bridge's UART command frames.
- For reads, receives and assembles the word the bridge returns.
- Used for chip-to-chip loading of instruction/data memory and as a synthesizable driver in loopback benches against the bridge.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per word).
- ADDR_WIDTH, 32, address width; fixed at 32 (4 address bytes).
- BAUD_RATE, 9600, UART bit rate.
- CLOCK_FREQ, 50000000, clk frequency in Hz. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, must be >= 4.
- CMD_READ, 8'h01, read command byte.
- CMD_WRITE, 8'hAA, write command byte.
- RESP_TIMEOUT_BITS, 64, read-response timeout in bit times.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  host idle, can accept.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  32  target word address.
- i_req_wdata  in  32  write data.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  32  read data; 0 for writes and errors.
- o_rsp_err  out  1  timeout or framing error; qualified by o_rsp_valid.
- o_uart_tx  out  1  serial out to bridge i_uart_rx.
- i_uart_rx  in  1  serial in from bridge o_uart_tx.
- o_start_rx  out  1  drives bridge i_start_rx.

Behaviour:
- Reset values: o_uart_tx=1, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_start_rx=0, FSM in IDLE.
- Reset asserted mid-frame aborts immediately: TX line high, no response issued.
- UART format: 8N1, LSB first, idle high. Each bit lasts exactly CLKS_PER_BIT cycles. Bytes are back-to-back with no inter-byte gap.
- Accept: on a clk edge with i_req_valid && o_req_ready, capture we/addr/wdata. o_req_ready is 0 from the next cycle until the cycle after the o_rsp_valid pulse.
- Frame order, MSB byte first:
  - Write: CMD_WRITE, addr[31:24..7:0], wdata[31:24..7:0] (9 bytes).
  - Read: CMD_READ, addr[31:24..7:0] (5 bytes), then receive 4 bytes MSB first.
- o_start_rx is high from the cycle after accept through the last TX stop bit.
- FSM states and transitions:
  - IDLE -> SEND_CMD on accept.
  - SEND_CMD -> SEND_ADDR.
  - SEND_ADDR (byte count 0..3) -> SEND_DATA if write, else RECV_DATA.
  - SEND_DATA (byte count 0..3) -> RESP.
  - RECV_DATA (byte count 0..3) -> RESP.
  - RESP: one cycle, then IDLE.
- Write latency: the first start bit begins the cycle after accept. o_rsp_valid pulses exactly 90*CLKS_PER_BIT+1 cycles after the accept edge, with rdata=0 and err=0.
- RX path:
  - i_uart_rx passes through a 2-flop synchronizer.
  - A start bit is a low level confirmed at mid-bit (CLKS_PER_BIT/2). Data bits are sampled at mid-bit.
  - A stop bit sampled 0 is a framing error: finish with err=1, rdata=0.
- Timeout: in RECV_DATA, a counter counts from the end of the previous byte (or the last TX stop bit). If no start bit arrives within RESP_TIMEOUT_BITS*CLKS_PER_BIT cycles, go to RESP with err=1, rdata=0.
- Read completion: o_rsp_valid pulses one cycle after the 4th byte's stop-bit sample.
- RX activity while not in RECV_DATA (including IDLE and during TX) is ignored and never corrupts a later read. The receiver is enabled only on entry to RECV_DATA, and only after the line has been seen idle-high.
- o_rsp_rdata/o_rsp_err hold their values until the next o_rsp_valid.

Decomposition:
- Package osiris_uart_pkg holds:
  - default CMD_READ/CMD_WRITE constants;
  - the host FSM state enum {IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, RECV_DATA, RESP};
  - a clks_per_bit function.
- One sub-module, uart_phy_8n1, holds the byte TX shifter, the byte RX sampler, and the synchronizer.
  - TX interface: tx_start/tx_byte/tx_busy/tx_done.
  - RX interface: rx_en/rx_byte/rx_valid/rx_frame_err.
- The top module holds the FSM, byte counters, and the timeout counter.

Test Plan (CLOCK_FREQ=8, BAUD_RATE=1, so CLKS_PER_BIT=8; RESP_TIMEOUT_BITS=4):
- Reset state: hold rst_n=0 -> o_uart_tx=1, o_req_ready=1, o_start_rx=0, o_rsp_valid=0.
- Write: we=1, addr=0x00000010, wdata=0xDEADBEEF -> TX decodes AA 00 00 00 10 DE AD BE EF. o_rsp_valid pulses at accept+721 with err=0 and rdata=0. o_req_ready=0 throughout.
- Read: we=0, addr=0x00000004, BFM replies 12 34 56 78 after the TX frame -> TX decodes 01 00 00 00 04. o_rsp_valid pulses with rdata=0x12345678, err=0.
- Timeout: read with no reply -> o_rsp_valid pulses with err=1 and rdata=0 exactly 32 cycles after the last TX stop bit. The next request is accepted normally.
- Framing error: the 3rd reply byte has stop bit=0 -> o_rsp_valid pulses with err=1, rdata=0, and the FSM returns to IDLE.
- Reset mid-frame: deassert rst_n during the 3rd address byte -> o_uart_tx=1 asynchronously and no o_rsp_valid. After release, a write request completes correctly; back-to-back write, read, and 0x00-byte requests all complete with correct bytes.
